// File: rtl/down_counter_timer_pkg.sv
// Shared constants and state encoding for the loadable down-counter timer.
package down_counter_timer_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/down_counter_timer_dff_sync_reset.sv
// Single-bit D flop with synchronous active-high reset and load enable.
module dff_sync_reset (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (reset)
      q <= 1'b0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counter with terminal-count done pulse and optional auto-reload.
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             zero,
  output logic             done
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] count_nxt;
  logic             state_bit_q;
  state_t           state;
  state_t           state_nxt;
  logic             done_q;
  logic             done_nxt;

  assign state = state_t'(state_bit_q);

  always_comb begin
    count_nxt = count_q;
    state_nxt = state;
    done_nxt  = 1'b0;
    if (load) begin
      count_nxt = load_value;
      state_nxt = (load_value != '0) ? RUN : IDLE;
    end else if (state == RUN && enable) begin
      if (count_q > WIDTH'(1)) begin
        count_nxt = count_q - WIDTH'(1);
      end else if (count_q == WIDTH'(1)) begin
        done_nxt = 1'b1;
        if (auto_reload) begin
          count_nxt = reload_q;
        end else begin
          count_nxt = '0;
          state_nxt = IDLE;
        end
      end else begin
        // A zero count while running cannot arise from a load; park safely.
        state_nxt = IDLE;
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bits
    dff_sync_reset u_count (
      .clk   (clk),
      .reset (reset),
      .en    (1'b1),
      .d     (count_nxt[i]),
      .q     (count_q[i])
    );
    // The reload register only captures on an explicit load.
    dff_sync_reset u_reload (
      .clk   (clk),
      .reset (reset),
      .en    (load),
      .d     (load_value[i]),
      .q     (reload_q[i])
    );
  end

  dff_sync_reset u_state (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .d     (state_nxt == RUN),
    .q     (state_bit_q)
  );

  dff_sync_reset u_done (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .d     (done_nxt),
    .q     (done_q)
  );

  assign count = count_q;
  assign busy  = (state == RUN);
  assign zero  = ~|count_q;
  assign done  = done_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed self-checking bench for down_counter_timer with WIDTH=4.
module tb_down_counter_timer;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             zero;
  logic             done;

  int checks   = 0;
  int failures = 0;

  down_counter_timer #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .load_value  (load_value),
    .enable      (enable),
    .auto_reload (auto_reload),
    .count       (count),
    .busy        (busy),
    .zero        (zero),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are sampled off the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b1; load_value = 4'd9; enable = 1'b1; auto_reload = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (count !== 4'd0 || busy !== 1'b0 || zero !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL reset_cyc%0d count=%0d busy=%b zero=%b done=%b required 0,0,1,0",
                 i, count, busy, zero, done);
      end
    end
    reset = 1'b0; load = 1'b0; auto_reload = 1'b0;
  endtask

  task automatic test_one_shot();
    logic [WIDTH-1:0] exp_cnt [5] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    load = 1'b1; load_value = 4'd5; enable = 1'b1; auto_reload = 1'b0;
    step();
    load = 1'b0;
    checks++;
    if (count !== 4'd5 || busy !== 1'b1 || done !== 1'b0 || zero !== 1'b0) begin
      failures++;
      $display("FAIL oneshot_load count=%0d busy=%b done=%b zero=%b required 5,1,0,0",
               count, busy, done, zero);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (count !== exp_cnt[i] || done !== (i == 4) || busy !== (i != 4)) begin
        failures++;
        $display("FAIL oneshot_step%0d count=%0d done=%b busy=%b required %0d,%b,%b",
                 i, count, done, busy, exp_cnt[i], (i == 4), (i != 4));
      end
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (count !== 4'd0 || done !== 1'b0 || busy !== 1'b0 || zero !== 1'b1) begin
        failures++;
        $display("FAIL oneshot_idle%0d count=%0d done=%b busy=%b zero=%b required 0,0,0,1",
                 i, count, done, busy, zero);
      end
    end
  endtask

  task automatic test_auto_reload();
    logic [WIDTH-1:0] exp_cnt [9] = '{4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3};
    int pulses = 0;
    load = 1'b1; load_value = 4'd3; enable = 1'b1; auto_reload = 1'b1;
    step();
    load = 1'b0;
    checks++;
    if (count !== 4'd3 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reload_load count=%0d busy=%b required 3,1", count, busy);
    end
    for (int i = 0; i < 9; i++) begin
      step();
      if (done === 1'b1) pulses++;
      checks++;
      if (count !== exp_cnt[i] || busy !== 1'b1 || done !== (exp_cnt[i] == 4'd3)) begin
        failures++;
        $display("FAIL reload_step%0d count=%0d busy=%b done=%b required %0d,1,%b",
                 i, count, busy, done, exp_cnt[i], (exp_cnt[i] == 4'd3));
      end
    end
    checks++;
    if (pulses != 3) begin
      failures++;
      $display("FAIL reload_pulses got=%0d required 3", pulses);
    end
    auto_reload = 1'b0;
  endtask

  task automatic test_enable_gap();
    logic             en_pat  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [WIDTH-1:0] exp_cnt [4] = '{4'd3, 4'd3, 4'd2, 4'd2};
    load = 1'b1; load_value = 4'd4; enable = 1'b0;
    step();
    load = 1'b0;
    checks++;
    if (count !== 4'd4 || busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL gap_load count=%0d busy=%b done=%b required 4,1,0", count, busy, done);
    end
    for (int i = 0; i < 4; i++) begin
      enable = en_pat[i];
      step();
      checks++;
      if (count !== exp_cnt[i] || done !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL gap_step%0d count=%0d done=%b busy=%b required %0d,0,1",
                 i, count, done, busy, exp_cnt[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    load = 1'b1; load_value = 4'd2; enable = 1'b1; auto_reload = 1'b0;
    step();
    load = 1'b0;
    step();
    checks++;
    if (count !== 4'd1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_pre count=%0d busy=%b required 1,1", count, busy);
    end
    // Load coincides with the terminal step and must win.
    load = 1'b1; load_value = 4'd6;
    step();
    checks++;
    if (count !== 4'd6 || done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_reload count=%0d done=%b busy=%b required 6,0,1", count, done, busy);
    end
    load_value = 4'd0;
    step();
    load = 1'b0;
    checks++;
    if (count !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || zero !== 1'b1) begin
      failures++;
      $display("FAIL b2b_load0 count=%0d busy=%b done=%b zero=%b required 0,0,0,1",
               count, busy, done, zero);
    end
    step();
    checks++;
    if (count !== 4'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_after0 count=%0d done=%b required 0,0", count, done);
    end
  endtask

  task automatic test_reset_abort();
    load = 1'b1; load_value = 4'd15; enable = 1'b1; auto_reload = 1'b0;
    step();
    load = 1'b0;
    for (int i = 0; i < 7; i++) step();
    checks++;
    if (count !== 4'd8 || busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre count=%0d busy=%b required 8,1", count, busy);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (count !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || zero !== 1'b1) begin
      failures++;
      $display("FAIL abort_reset count=%0d busy=%b done=%b zero=%b required 0,0,0,1",
               count, busy, done, zero);
    end
    for (int i = 0; i < 4; i++) begin
      auto_reload = i[0];
      step();
      checks++;
      if (count !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL abort_idle%0d count=%0d busy=%b done=%b required 0,0,0",
                 i, count, busy, done);
      end
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; load_value = '0; enable = 1'b0; auto_reload = 1'b0;
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_enable_gap();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
